// File: rtl/debounce_pulsadores_pkg.sv
// Shared constants for the pushbutton front-end of the ALU loader.
// Channel map ties each button to the loader strobe it drives.
package debounce_pulsadores_pkg;
    localparam int N_BTN_DEF      = 3;
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int DEB_CYCLES_SIM = 4;

    localparam int BTN_NR1 = 0;
    localparam int BTN_NR2 = 1;
    localparam int BTN_OP  = 2;
endpackage

// File: rtl/debounce_pulsadores_if.sv
// Button bundle between the board pins and the loader strobes.
// master drives raw levels; slave returns debounced level and pulse.
interface debounce_pulsadores_if
    import debounce_pulsadores_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_level;

    modport master (
        output btn_raw,
        input  btn_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        output btn_pulse,
        output btn_level
    );
endinterface

// File: rtl/debounce_pulsadores_bit.sv
// One button channel: 2-flop sync, stability counter, level and
// single-cycle press pulse registered on the same edge.
module debounce_bit #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse,
    output logic btn_level
);
    localparam int CNT_W =
        (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            s1        <= btn_raw;
            s2        <= s1;
            btn_pulse <= 1'b0;
            if (s2 == btn_level) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end else begin
                // accepted change; only a rising edge pulses
                cnt       <= '0;
                btn_level <= s2;
                btn_pulse <= s2;
            end
        end
    end
endmodule

// File: rtl/debounce_pulsadores.sv
// Pushbutton conditioning: N_BTN independent debounce channels.
// Pulses feed the loader p1/p2/p3 strobes directly.
module debounce_pulsadores
    import debounce_pulsadores_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    debounce_pulsadores_if.slave bus
);
    logic [N_BTN-1:0] pulse_w;
    logic [N_BTN-1:0] level_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .btn_raw   (bus.btn_raw[i]),
            .btn_pulse (pulse_w[i]),
            .btn_level (level_w[i])
        );
    end

    assign bus.btn_pulse = pulse_w;
    assign bus.btn_level = level_w;
endmodule

// File: tb/tb_debounce_pulsadores.sv
// Directed bench for debounce_pulsadores with a 4-cycle debounce.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_debounce_pulsadores;
    import debounce_pulsadores_pkg::*;

    localparam int NB = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    debounce_pulsadores_if #(.N_BTN(NB)) bus ();

    debounce_pulsadores #(
        .N_BTN      (NB),
        .DEB_CYCLES (DEB_CYCLES_SIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [NB-1:0] obs,
                       input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    task automatic both(input string tag,
                        input logic [NB-1:0] lvl,
                        input logic [NB-1:0] pls);
        chk({tag, " level"}, bus.btn_level, lvl);
        chk({tag, " pulse"}, bus.btn_pulse, pls);
    endtask

    initial begin
        // 1: reset held with all buttons pressed
        bus.btn_raw = 3'b111;
        #1;
        both("rst_async", 3'b000, 3'b000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            both($sformatf("rst_c%0d", k), 3'b000, 3'b000);
        end
        reset = 1'b1;
        bus.btn_raw = 3'b000;
        repeat (3) @(negedge clk);
        both("post_rst", 3'b000, 3'b000);

        // 2: press ch0, hold 20 cycles
        bus.btn_raw = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            both($sformatf("p0_k%0d", k),
                 (k >= 6) ? 3'b001 : 3'b000,
                 (k == 6) ? 3'b001 : 3'b000);
        end

        // 3: ch1 glitches of 3 cycles, rejected
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6; k++) begin
                bus.btn_raw = (k < 3) ? 3'b011 : 3'b001;
                @(negedge clk);
                both($sformatf("gl_r%0d_k%0d", r, k),
                     3'b001, 3'b000);
            end
        end

        // release ch0
        bus.btn_raw = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            both($sformatf("r0_k%0d", k),
                 (k < 6) ? 3'b001 : 3'b000, 3'b000);
        end

        // 4: simultaneous press ch0 and ch2
        bus.btn_raw = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            both($sformatf("sim_k%0d", k),
                 (k >= 6) ? 3'b101 : 3'b000,
                 (k == 6) ? 3'b101 : 3'b000);
        end
        bus.btn_raw = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            both($sformatf("simr_k%0d", k),
                 (k < 6) ? 3'b101 : 3'b000, 3'b000);
        end

        // 5: ch2 press, release, press again
        bus.btn_raw = 3'b100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            both($sformatf("p2a_k%0d", k),
                 (k >= 6) ? 3'b100 : 3'b000,
                 (k == 6) ? 3'b100 : 3'b000);
        end
        bus.btn_raw = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            both($sformatf("r2_k%0d", k),
                 (k < 6) ? 3'b100 : 3'b000, 3'b000);
        end
        bus.btn_raw = 3'b100;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            both($sformatf("p2b_k%0d", k),
                 (k >= 6) ? 3'b100 : 3'b000,
                 (k == 6) ? 3'b100 : 3'b000);
        end
        bus.btn_raw = 3'b000;
        repeat (8) @(negedge clk);
        both("idle", 3'b000, 3'b000);

        // 6: ch0 held, reset mid-count then mid-pulse
        bus.btn_raw = 3'b001;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        both("rst_midcnt", 3'b000, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            both($sformatf("rc_k%0d", k),
                 (k >= 6) ? 3'b001 : 3'b000,
                 (k == 6) ? 3'b001 : 3'b000);
        end
        #2 reset = 1'b0;
        #1;
        both("rst_midpls", 3'b000, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            both($sformatf("rp_k%0d", k),
                 (k >= 6) ? 3'b001 : 3'b000,
                 (k == 6) ? 3'b001 : 3'b000);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
